mc_mem_responder: RTL and testbench

- Memory-side responder for the multicycle RV32 core's data/instruction memory port, which is the target end of the core's load/store requests.
- It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- It performs byte-enabled writes into an internal word array named RAM, so that benches can preload it with $readmemh.
- It returns read data or an error over a valid/ready response channel.

---
 rtl/mc_mem_if.sv | 40 ++++
 rtl/mc_mem_responder.sv | 125 ++++++++++++
 tb/tb_mc_mem_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_mem_if.sv
// Request/response bundle between the multicycle core and its memory.
// The master drives requests and accepts responses; the slave does the reverse.
interface mc_mem_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_ready;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output req_be,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/mc_mem_responder.sv
// Single-outstanding memory responder with programmable wait states.
// RAM is touched once, on the edge that enters RESP.
module mc_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  mc_mem_if.slave bus
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] RAM [DEPTH_WORDS];

  logic [31:0]   off;
  logic          misal;
  logic          oob;
  logic          addr_err;
  logic [AW-1:0] idx;
  logic          enter_resp;
  logic          ram_wr;

  // BASE_ADDR is word-aligned, so the offset's low bits mirror the address.
  always_comb begin
    off        = lat_addr - BASE_ADDR;
    misal      = |off[1:0];
    oob        = |off[31:AW+2];
    addr_err   = misal | oob;
    idx        = off[AW+1:2];
    enter_resp = (state == WAIT) && (cnt == 4'd0);
    ram_wr     = enter_resp && lat_we
                 && !addr_err && !rst;
  end

  assign bus.req_ready = ready_q & ~rst;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
            cnt       <= LAT;
            ready_q   <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            valid_q <= 1'b1;
            err_q   <= addr_err;
            if (!lat_we && !addr_err)
              rdata_q <= RAM[idx];
            else
              rdata_q <= 32'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i])
          RAM[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed plus randomized bench for mc_mem_responder against a word-array model.
// A second instance covers the zero-wait-state build.
module tb_mc_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mc_mem_if bus ();
  mc_mem_if bus0 ();

  mc_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  mc_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(0),
    .BASE_ADDR(BASE)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] mem0 [DEPTH];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_err(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o[1:0] != 2'd0) || ((o >> 2) >= DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % DEPTH;
  endfunction

  task automatic txn(input logic        we,
                     input logic [31:0] addr,
                     input logic [31:0] wd,
                     input logic [3:0]  be,
                     input int          stall,
                     input bit          hold);
    logic        e_err;
    logic [31:0] e_rd;
    int          w;
    int          lat;
    e_err = is_err(addr);
    e_rd  = 32'd0;
    if (!e_err && !we) e_rd = mem[widx(addr)];
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    bus.rsp_ready = (stall == 0);
    w = 0;
    while (!bus.req_ready && w < 50) begin
      cyc();
      w++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    cyc();
    if (!hold) bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
    chk("ready_after_accept", 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      cyc();
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT + 1));
    chk("rdata", bus.rsp_rdata, e_rd);
    chk("err", 32'(bus.rsp_err), 32'(e_err));
    if (we && !e_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx(addr)][8*i +: 8] = wd[8*i +: 8];
    end
    for (int s = 1; s < stall; s++) begin
      cyc();
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, e_rd);
      chk("hold_err", 32'(bus.rsp_err), 32'(e_err));
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("post_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_rdata", bus.rsp_rdata, 32'd0);
    chk("post_err", 32'(bus.rsp_err), 32'd0);
    chk("post_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic txn0(input logic        we,
                      input logic [31:0] addr,
                      input logic [31:0] wd);
    logic [31:0] e_rd;
    int          w;
    int          lat;
    e_rd = we ? 32'd0 : mem0[widx(addr)];
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wd;
    bus0.req_be    = 4'hF;
    bus0.rsp_ready = 1'b1;
    w = 0;
    while (!bus0.req_ready && w < 50) begin
      cyc();
      w++;
    end
    cyc();
    bus0.req_valid = 1'b0;
    lat = 0;
    while (!bus0.rsp_valid && lat < 40) begin
      cyc();
      lat++;
    end
    chk("l0_latency", 32'(lat), 32'd1);
    chk("l0_rdata", bus0.rsp_rdata, e_rd);
    chk("l0_err", 32'(bus0.rsp_err), 32'd0);
    if (we) mem0[widx(addr)] = wd;
    cyc();
    chk("l0_post_valid", 32'(bus0.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          w;
    int          r;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_be     = 4'd0;
    bus.rsp_ready  = 1'b1;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'd0;
    bus0.req_wdata = 32'd0;
    bus0.req_be    = 4'd0;
    bus0.rsp_ready = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst0_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++)
      txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);

    txn(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
    chk("model_word0", mem[0], 32'hDEADBEEF);

    txn(1'b1, 32'h4, 32'hAABBCCDD, 4'hF, 0, 1'b0);
    txn(1'b1, 32'h4, 32'h11223344, 4'b0101, 0, 1'b0);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0);

    txn(1'b0, 32'h2, 32'h0, 4'h0, 0, 1'b0);
    txn(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      txn(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, 1'b0);

    txn(1'b0, 32'h8, 32'h0, 4'h0, 6, 1'b1);
    txn(1'b0, 32'hC, 32'h0, 4'h0, 0, 1'b0);

    txn(1'b1, 32'h10, 32'h5A5A5A5A, 4'h0, 0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'hC;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_be    = 4'hF;
    bus.rsp_ready = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      cyc();
      w++;
    end
    cyc();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(bus.req_ready), 32'd1);
    cyc();
    chk("midrst_idle_valid", 32'(bus.rsp_valid), 32'd0);
    txn(1'b0, 32'hC, 32'h0, 4'h0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7)
        a = (32'($urandom_range(0, DEPTH - 1)) << 2)
            | 32'($urandom_range(1, 3));
      else if (r == 8)
        a = 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
      else
        a = ($urandom | 32'h1000) & ~32'h3;
      txn(1'($urandom), a, $urandom, 4'($urandom),
          $urandom_range(0, 3), 1'($urandom));
    end
    bus.req_valid = 1'b0;

    txn0(1'b1, 32'h8, 32'h00000013);
    txn0(1'b0, 32'h8, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
